// File: rtl/lms_pkg.sv
// Shared types, width helpers and the saturation primitive for the LMS filter core.
package lms_pkg;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_MAC  = 3'd1;
  localparam state_t S_ERR  = 3'd2;
  localparam state_t S_UPD  = 3'd3;
  localparam state_t S_DONE = 3'd4;

  typedef struct packed {
    logic [63:0] val;
    logic        clamp;
  } sat_res_t;

  function automatic int calc_tw(input int taps);
    return (taps <= 1) ? 1 : $clog2(taps);
  endfunction

  // Accumulator sized so TAPS full-scale products cannot overflow.
  function automatic int calc_acc_w(input int data_w, input int taps);
    return 2 * data_w + calc_tw(taps);
  endfunction

  function automatic sat_res_t saturate(input logic signed [63:0] v, input int out_w);
    logic signed [63:0] hi, lo;
    sat_res_t r;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    r.clamp = 1'b1;
    if (v > hi)      r.val = hi;
    else if (v < lo) r.val = lo;
    else begin
      r.val   = v;
      r.clamp = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/lms_sat.sv
// Signed narrowing saturator IN_W -> DATA_W with a clamp indication.
module lms_sat
  import lms_pkg::*;
#(
  parameter int IN_W   = 18,
  parameter int DATA_W = 8
)(
  input  logic signed [IN_W-1:0]   din,
  output logic signed [DATA_W-1:0] dout,
  output logic                     clamp
);

  sat_res_t r;
  logic     unused_hi;

  always_comb begin
    r     = saturate(64'(din), DATA_W);
    dout  = r.val[DATA_W-1:0];
    clamp = r.clamp;
  end

  assign unused_hi = ^r.val[63:DATA_W];

endmodule

// File: rtl/lms_filter_core.sv
// LMS adaptive FIR: delay line + weight bank sharing one multiplier between
// the MAC pass and the weight-update pass.
module lms_filter_core
  import lms_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int TAPS     = 4,
  parameter int FRAC_W   = 6,
  parameter int MU_SHIFT = 2,
  localparam int TW      = calc_tw(TAPS)
)(
  input  logic                     clock,
  input  logic                     sys_reset_n,
  input  logic signed [DATA_W-1:0] Xn,
  input  logic signed [DATA_W-1:0] Dn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     adapt_en,
  input  logic                     w_load,
  input  logic [TW-1:0]            w_addr,
  input  logic signed [DATA_W-1:0] Wn,
  output logic signed [DATA_W-1:0] yn,
  output logic signed [DATA_W-1:0] en,
  output logic                     out_valid,
  output logic                     sat,
  output logic                     busy
);

  localparam int            ACC_W  = calc_acc_w(DATA_W, TAPS);
  localparam int            PW     = 2 * DATA_W;
  localparam logic [TW-1:0] K_LAST = TW'(TAPS - 1);

  state_t                         state;
  logic [TAPS-1:0][DATA_W-1:0]    x_q, w_q;
  logic signed [DATA_W-1:0]       d_q;
  logic                           adapt_q;
  logic [TW-1:0]                  k;
  logic signed [ACC_W-1:0]        acc;

  logic signed [DATA_W-1:0] x_k, w_k, mul_a;
  logic signed [PW-1:0]     prod, prod_sh;
  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [DATA_W:0]   e_wide, w_sum;
  logic signed [DATA_W-1:0] y_sat, e_sat, delta, w_new;
  logic                     y_clamp, e_clamp, d_clamp, w_clamp;

  // The single multiplier: weight*x during MAC, error*x during UPDATE.
  assign x_k     = $signed(x_q[k]);
  assign w_k     = $signed(w_q[k]);
  assign mul_a   = (state == S_UPD) ? en : w_k;
  assign prod    = mul_a * x_k;

  assign acc_sh  = acc >>> FRAC_W;
  assign e_wide  = $signed({d_q[DATA_W-1], d_q}) - $signed({y_sat[DATA_W-1], y_sat});
  assign prod_sh = prod >>> (FRAC_W + MU_SHIFT);
  assign w_sum   = $signed({w_k[DATA_W-1], w_k}) + $signed({delta[DATA_W-1], delta});

  lms_sat #(.IN_W(ACC_W),    .DATA_W(DATA_W)) u_sat_y (.din(acc_sh),  .dout(y_sat), .clamp(y_clamp));
  lms_sat #(.IN_W(DATA_W+1), .DATA_W(DATA_W)) u_sat_e (.din(e_wide),  .dout(e_sat), .clamp(e_clamp));
  lms_sat #(.IN_W(PW),       .DATA_W(DATA_W)) u_sat_d (.din(prod_sh), .dout(delta), .clamp(d_clamp));
  lms_sat #(.IN_W(DATA_W+1), .DATA_W(DATA_W)) u_sat_w (.din(w_sum),   .dout(w_new), .clamp(w_clamp));

  assign in_ready  = (state == S_IDLE) && !w_load;
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state   <= S_IDLE;
      x_q     <= '0;
      w_q     <= '0;
      d_q     <= '0;
      adapt_q <= 1'b0;
      k       <= '0;
      acc     <= '0;
      yn      <= '0;
      en      <= '0;
      sat     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (w_load) begin
            w_q[w_addr] <= Wn;
          end else if (in_valid) begin
            x_q     <= {x_q[TAPS-2:0], Xn};
            d_q     <= Dn;
            adapt_q <= adapt_en;
            acc     <= '0;
            sat     <= 1'b0;
            k       <= '0;
            state   <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + ACC_W'(prod);
          k   <= k + TW'(1);
          if (k == K_LAST) begin
            k     <= '0;
            state <= S_ERR;
          end
        end
        S_ERR: begin
          yn    <= y_sat;
          en    <= e_sat;
          sat   <= sat | y_clamp | e_clamp;
          k     <= '0;
          state <= adapt_q ? S_UPD : S_DONE;
        end
        S_UPD: begin
          w_q[k] <= w_new;
          sat    <= sat | d_clamp | w_clamp;
          k      <= k + TW'(1);
          if (k == K_LAST) begin
            k     <= '0;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
